// File: rtl/if_stage.sv
// if_stage: instruction fetch for the 32-bit MIPS pipeline.
// Owns the PC, fetches from 1-cycle imem, buffers words for decode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [7:0]  fetch_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    fc;

  logic [31:0] buf_instr [BUF_DEPTH];
  logic [31:0] buf_pc    [BUF_DEPTH];

  logic          pop;
  logic          push;
  logic [OW-1:0] occ;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & id_ready;
  assign push        = inflight & ~redirect;

  // Pop credit lets a full buffer keep fetching while decode drains it.
  assign occ = {1'b0, count}
             + OW'(inflight)
             - OW'(pop);

  assign imem_req  = ~rst & ~redirect
                   & (occ < OW'(BUF_DEPTH));
  assign imem_addr = pc;

  assign instruction = instr_valid ? buf_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign pc_plus4    = instr_valid ? buf_pc[rd_ptr] + 32'd4 : 32'h0;
  assign fetch_count = fc;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fc          <= 8'h0;
    end else begin
      fc <= fc + 8'(pop);
      if (redirect) begin
        pc       <= redirect_pc & 32'hFFFF_FFFC;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= imem_req;
        if (imem_req) begin
          pc          <= pc + 32'd4;
          inflight_pc <= pc;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage in the 32-bit MIPS pipeline. It owns the PC and issues word fetches to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered in a small FIFO and presented to decode through a valid/ready handshake. It supports redirect (branch/jump) with flush of the FIFO and any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
BUF_DEPTH, 2, instruction FIFO entries; power of two, >= 2.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
imem_req  output  1  fetch request; memory always accepts.
imem_addr  output  32  byte address of the fetch; equals current PC.
imem_rdata  input  32  instruction word; valid exactly one cycle after an accepted request.
redirect  input  1  taken branch/jump; overrides all other activity this cycle.
redirect_pc  input  32  new PC; bits [1:0] are forced to 00 internally.
id_ready  input  1  decode accepts the head instruction this cycle.
instr_valid  output  1  FIFO head is valid.
instruction  output  32  FIFO head word; 32'h0 (NOP) when instr_valid=0.
instr_pc  output  32  PC of the head word; 0 when instr_valid=0.
pc_plus4  output  32  instr_pc+4, mod 2^32; 0 when instr_valid=0.
fetch_count  output  8  number of instructions handed to decode; wraps 255->0.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; FIFO empty; in-flight flag cleared; fetch_count=0.
  - imem_req=0, instr_valid=0; instruction, instr_pc and pc_plus4 = 0.
- Pop: pop = instr_valid & id_ready. Head outputs are combinational from FIFO storage.
- Request rule: imem_req = !redirect & (count + inflight - pop < BUF_DEPTH), where inflight is the registered request flag from the previous cycle. Pop credit gives full throughput when id_ready is held high.
- On imem_req: pc <= pc+4 (wraps 0xFFFF_FFFC -> 0x0). inflight <= 1 and inflight_pc <= pc. Otherwise inflight <= 0.
- Response: in the cycle after a request (inflight=1), imem_rdata and inflight_pc are pushed at the clock edge.
- Latency: request issued in cycle N; data present in cycle N+1; instr_valid first high in cycle N+2. The first request is in the first cycle after rst deasserts, so the first instr_valid comes 2 cycles after release.
- Push and pop in the same cycle are legal; count is unchanged. The push never overflows, guaranteed by the request rule; the bench asserts this.
- Redirect (highest priority):
  - pc <= {redirect_pc[31:2],2'b00}; FIFO count, read and write pointers cleared.
  - Any response arriving this cycle is discarded; inflight <= 0; imem_req=0 this cycle.
  - A pop in the same cycle still counts: decode consumed the head, so fetch_count increments.
  - First request at the new PC is in the next cycle; its instr_valid follows 2 cycles after that request.
- Back-to-back redirects: each restarts the sequence; only the last target is fetched.
- fetch_count increments by 1 on every pop; 8-bit wrap.
- Reset mid-operation: all state is cleared immediately and the in-flight response is ignored. Memory data seen after release is not pushed until a new request has been made.
- No X propagation: the FIFO storage reset is not required, but outputs are gated to 0 when empty.

Test Plan:
- Reset release, RESET_PC=0, memory word at addr i = 32'h1000_0000+i, id_ready=1 -> imem_addr 0,4,8 in consecutive cycles; instr_valid rises 2 cycles after release; stream instr_pc=0,4,8,... with no bubbles; fetch_count increments every cycle.
- id_ready=0 for 5 cycles mid-stream -> requests stop after FIFO+in-flight reach BUF_DEPTH (2); instr_valid stays high; head stays stable. On id_ready=1, delivery resumes in PC order with no loss or duplication.
- redirect=1, redirect_pc=32'h0000_0403 while FIFO full and a fetch is in flight -> next-cycle imem_addr=32'h400; instr_valid=0 for 2 cycles; the next delivered instr_pc is 0x400, and no stale words appear.
- redirect in the same cycle as a pop -> fetch_count increments once; FIFO is cleared; delivery resumes at the target.
- PC wrap: redirect to 32'hFFFF_FFF8, id_ready=1 -> instr_pc=FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 for FFFF_FFFC is 0.
- rst asserted asynchronously mid-stream (between edges) -> outputs 0 immediately. After release, fetch restarts at RESET_PC and fetch_count=0; the response to the pre-reset request is never delivered.
